// File: rtl/print_job_arbiter_pkg.sv
// Shared types and constants for the print job arbiter.
// Status layout matches the 5-bit isPritting PIO in_port.
package print_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    RUN,
    RELEASE
  } state_e;

  localparam int ST_W        = 5;
  localparam int ST_BUSY     = 4;
  localparam int ST_OWNER_HI = 3;
  localparam int ST_OWNER_LO = 2;
  localparam int ST_TOERR    = 1;
  localparam int ST_PEND     = 0;

  localparam int OWN_W = 2;

  function automatic logic [OWN_W-1:0] rr_next(
    input logic [OWN_W-1:0] o,
    input int               n
  );
    if (int'(o) >= n - 1) return '0;
    return o + OWN_W'(1);
  endfunction

endpackage

// File: rtl/print_job_arbiter_if.sv
// Requester and engine handshake bundle of the print job arbiter.
// The arbiter uses master; requesters and engine use slave.
interface print_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CMD_W = 32
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_done;
  logic                   eng_start;
  logic [CMD_W-1:0]       eng_cmd;
  logic                   eng_abort;
  logic                   eng_done;

  modport master (
    input  req_valid,
    input  req_cmd,
    input  eng_done,
    output req_ready,
    output req_done,
    output eng_start,
    output eng_cmd,
    output eng_abort
  );

  modport slave (
    output req_valid,
    output req_cmd,
    output eng_done,
    input  req_ready,
    input  req_done,
    input  eng_start,
    input  eng_cmd,
    input  eng_abort
  );

endinterface

// File: rtl/print_job_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping modulo N_REQ.
module rr_picker
  import print_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic [OWN_W-1:0] win,
  output logic             win_vld
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!win_vld && req[jj]) begin
        win     = OWN_W'(j);
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/print_job_arbiter.sv
// Shares the frame-buffer print engine between requesters with
// round-robin grants, a start/done handshake and a run watchdog.
module print_job_arbiter
  import print_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int CMD_W       = 32,
  parameter  int TIMEOUT_CYC = 1000000,
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk,
  input  logic            reset,
  print_job_arbiter_if.master bus,
  input  logic            err_clr,
  output logic [ST_W-1:0] status
);

  state_e            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  rr_q, rr_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic [TO_W-1:0]   wd_q, wd_d, wd_inc;
  logic              err_q, err_d;
  logic              set_err;
  logic [ST_W-1:0]   status_q, status_d;

  logic [OWN_W-1:0]  win;
  logic              win_vld;
  logic [N_REQ-1:0]  own_oh;
  logic              busy;
  logic [CMD_W-1:0]  cmds [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_cmd
    assign cmds[g] = bus.req_cmd[g*CMD_W +: CMD_W];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_q),
    .win     (win),
    .win_vld (win_vld)
  );

  assign own_oh = N_REQ'(1) << owner_q;
  assign busy   = (state_q != IDLE);
  assign wd_inc = wd_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cmd_d   = cmd_q;
    rdy_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    abort_d = 1'b0;
    wd_d    = wd_q;
    set_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win;
          cmd_d   = cmds[win];
          rdy_d   = N_REQ'(1) << win;
        end
      end
      GRANT: begin
        state_d = START;
        start_d = 1'b1;
      end
      START: begin
        state_d = RUN;
        wd_d    = '0;
      end
      RUN: begin
        // Done beats a watchdog expiry landing in the same cycle.
        if (bus.eng_done) begin
          state_d = RELEASE;
          done_d  = own_oh;
        end else if (wd_inc == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = RELEASE;
          done_d  = own_oh;
          abort_d = 1'b1;
          set_err = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        rr_d    = rr_next(owner_q, N_REQ);
      end
      default: state_d = IDLE;
    endcase

    if (set_err)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    status_d = '0;
    status_d[ST_BUSY] = busy;
    status_d[ST_OWNER_HI:ST_OWNER_LO] = owner_q;
    status_d[ST_TOERR] = err_q;
    status_d[ST_PEND] =
      |(bus.req_valid & ~(busy ? own_oh : '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      cmd_q    <= '0;
      rdy_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cmd_q    <= cmd_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.req_done  = done_q;
  assign bus.eng_start = start_q;
  assign bus.eng_cmd   = cmd_q;
  assign bus.eng_abort = abort_q;
  assign status        = status_q;

endmodule
